// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: PC_SEL encodings,
// fetch FSM states and the default bubble instruction.
package inst_fetch_pkg;

  localparam logic [1:0] PCS_HOLD = 2'b00;
  localparam logic [1:0] PCS_INC  = 2'b01;
  localparam logic [1:0] PCS_BR   = 2'b10;
  localparam logic [1:0] PCS_REG  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // Opcode field of this word decodes to no control action downstream.
  localparam logic [31:0] BUBBLE_DEFAULT = 32'h0400_0000;

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Combinational next-PC selection: hold, PC+4, PC-relative or absolute branch,
// register jump. Reports a misaligned target for the optional alignment check.
module inst_fetch_next_pc
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [1:0]      pc_sel_i,
  input  logic            pc_mux_i,
  input  logic [63:0]     k_i,
  input  logic            off19_i,
  input  logic [PC_W-1:0] a_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] offsetWords;
  logic [PC_W-1:0] relTarget;
  logic            unused_k;

  // K is a word offset; only the low 19 or 26 bits carry meaning (PC_W >= 28).
  assign unused_k = ^k_i[63:26];

  always_comb begin
    offsetWords = '0;
    if (off19_i) begin
      offsetWords = {{(PC_W-19){k_i[18]}}, k_i[18:0]};
    end else begin
      offsetWords = {{(PC_W-26){k_i[25]}}, k_i[25:0]};
    end
    relTarget = pc_i + (offsetWords << 2);
  end

  always_comb begin
    next_pc_o = pc_i;
    case (pc_sel_i)
      PCS_HOLD: next_pc_o = pc_i;
      PCS_INC:  next_pc_o = pc_i + PC_W'(4);
      PCS_BR:   next_pc_o = pc_mux_i ? relTarget : a_i;
      PCS_REG:  next_pc_o = a_i;
      default:  next_pc_o = pc_i;
    endcase
  end

  assign misalign_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns PC and IR, runs the memory req/ack handshake and applies
// the control unit's next-PC decision. INST_FETCH_ALIGN_CHK_EN adds align_fault/HALT.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int               PC_W      = 32,
  parameter logic [PC_W-1:0]  RESET_VEC = '0,
  parameter logic [31:0]      BUBBLE    = BUBBLE_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      PC_SEL,
  input  logic            PC_MUX,
  input  logic [63:0]     K,
  input  logic            OFF19,
  input  logic [PC_W-1:0] A_in,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     Inst,
  output logic            inst_valid,
  output logic [PC_W-1:0] PC
`ifdef INST_FETCH_ALIGN_CHK_EN
  ,
  output logic            align_fault
`endif
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic [31:0]     ir_q;
  logic            valid_q;
  logic            req_q;
  logic [PC_W-1:0] next_pc_raw;
  logic [PC_W-1:0] pc_d;
  logic            misalign;

  inst_fetch_next_pc #(
    .PC_W(PC_W)
  ) uNextPc (
    .pc_i      (pc_q),
    .pc_sel_i  (PC_SEL),
    .pc_mux_i  (PC_MUX),
    .k_i       (K),
    .off19_i   (OFF19),
    .a_i       (A_in),
    .next_pc_o (next_pc_raw),
    .misalign_o(misalign)
  );

`ifdef INST_FETCH_ALIGN_CHK_EN
  logic fault_q;
  assign pc_d        = next_pc_raw;
  assign align_fault = fault_q;
`else
  // Without the checker a misaligned target is silently rounded down to a word.
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign pc_d            = {next_pc_raw[PC_W-1:2], 2'b00};
`endif

  // Request is raised one cycle after entering FETCH; the IR is cleared to a
  // bubble whenever the PC moves so a stale instruction can never be re-issued.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VEC;
      addr_q  <= RESET_VEC;
      ir_q    <= BUBBLE;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end else if (mem_ack) begin
            ir_q    <= mem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (PC_SEL != PCS_HOLD) begin
            valid_q <= 1'b0;
            ir_q    <= BUBBLE;
`ifdef INST_FETCH_ALIGN_CHK_EN
            if (misalign) begin
              fault_q <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q    <= pc_d;
              state_q <= FETCH;
            end
`else
            pc_q    <= pc_d;
            state_q <= FETCH;
`endif
          end
        end
        default: begin
`ifdef INST_FETCH_ALIGN_CHK_EN
          state_q <= HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
`else
          state_q <= FETCH;
`endif
        end
      endcase
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign PC         = pc_q;
  assign inst_valid = valid_q;
  assign Inst       = valid_q ? ir_q : BUBBLE;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus queues expected fetch addresses and
// delivered instructions, a negedge monitor pops and compares them.
module tb_inst_fetch;

   localparam logic [31:0] BUBBLE_W = 32'h0400_0000;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  PC_SEL = 2'b00;
   logic        PC_MUX = 1'b0;
   logic [63:0] K = '0;
   logic        OFF19 = 1'b0;
   logic [31:0] A_in = '0;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] Inst;
   logic        inst_valid;
   logic [31:0] PC;
`ifdef INST_FETCH_ALIGN_CHK_EN
   logic        alignFault;
`endif

   int testsRun = 0;
   int failures = 0;

   logic [31:0] expAddrQ[$];
   logic [63:0] expInstQ[$];
   logic        prevReq = 1'b0;
   logic        prevValid = 1'b0;
   logic [31:0] pcNow;

   inst_fetch dut (
      .CLK(CLK), .Reset(Reset), .PC_SEL(PC_SEL), .PC_MUX(PC_MUX), .K(K),
      .OFF19(OFF19), .A_in(A_in), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Inst(Inst),
      .inst_valid(inst_valid), .PC(PC)
`ifdef INST_FETCH_ALIGN_CHK_EN
      , .align_fault(alignFault)
`endif
   );

   always #5 CLK = ~CLK;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      testsRun++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: a rising mem_req must match the next expected fetch address and a
   // rising inst_valid must match the next expected instruction and its PC.
   always @(negedge CLK) begin
      if (!Reset) begin
         if (mem_req && !prevReq) begin
            if (expAddrQ.size() == 0) reportTimeout("unexpected_req");
            else checkOutput("fetch_addr", 64'(mem_addr), 64'(expAddrQ.pop_front()));
         end
         if (inst_valid && !prevValid) begin
            if (expInstQ.size() == 0) reportTimeout("unexpected_inst");
            else checkOutput("inst_and_pc", {Inst, PC}, expInstQ.pop_front());
         end
      end
      prevReq   = mem_req;
      prevValid = inst_valid;
   end

   task automatic waitReq(input string name);
      int n = 0;
      @(negedge CLK);
      while (!mem_req && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!mem_req) reportTimeout(name);
   endtask

   task automatic waitValid(input string name);
      int n = 0;
      @(negedge CLK);
      while (!inst_valid && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!inst_valid) reportTimeout(name);
   endtask

   task automatic applyReset();
      @(posedge CLK); #1;
      Reset = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_req", 64'(mem_req), 64'd0);
      checkOutput("rst_valid", 64'(inst_valid), 64'd0);
      checkOutput("rst_inst", 64'(Inst), 64'(BUBBLE_W));
      checkOutput("rst_pc", 64'(PC), 64'd0);
      checkOutput("rst_addr", 64'(mem_addr), 64'd0);
      expAddrQ.push_back(32'h0);
      @(posedge CLK); #1;
      Reset = 1'b0;
   endtask

   // Answers the pending request after 'delay' extra cycles.
   task automatic applyStimulus(input logic [31:0] rdata, input int delay, input logic [31:0] expPc);
      expInstQ.push_back({rdata, expPc});
      waitReq("fetch_req");
      checkOutput("inst_bubble_while_fetch", 64'(Inst), 64'(BUBBLE_W));
      repeat (delay) @(posedge CLK);
      @(posedge CLK); #1;
      mem_ack = 1'b1;
      mem_rdata = rdata;
      @(posedge CLK); #1;
      mem_ack = 1'b0;
      waitValid("fetch_valid");
   endtask

   // One-cycle control decision presented in EXEC.
   task automatic exec(input logic [1:0] sel, input logic mux, input logic off, input logic [63:0] kv,
                       input logic [31:0] a, input logic [31:0] expNext);
      expAddrQ.push_back(expNext);
      @(posedge CLK); #1;
      PC_SEL = sel; PC_MUX = mux; OFF19 = off; K = kv; A_in = a;
      @(posedge CLK); #1;
      PC_SEL = 2'b00;
      @(negedge CLK);
      checkOutput("valid_drop_after_exec", 64'(inst_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      applyReset();
      applyStimulus(32'h8B02_0020, 2, 32'h0);

      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'h40, 32'h40);
      applyStimulus(32'h1111_0040, 0, 32'h40);
      exec(2'b01, 1'b0, 1'b0, 64'h0, 32'h0, 32'h44);
      applyStimulus(32'h2222_0044, 1, 32'h44);

      // Multicycle hold with a stray ack and PC_SEL noise-free hold.
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         mem_ack = (i == 1);
         mem_rdata = 32'hDEAD_BEEF;
         @(negedge CLK);
         checkOutput("hold_inst", 64'(Inst), 64'h2222_0044);
         checkOutput("hold_req", 64'(mem_req), 64'd0);
         checkOutput("hold_pc", 64'(PC), 64'h44);
      end
      mem_ack = 1'b0;
      exec(2'b01, 1'b0, 1'b0, 64'h0, 32'h0, 32'h48);
      // PC_SEL driven during FETCH must be ignored.
      @(posedge CLK); #1;
      PC_SEL = 2'b11; A_in = 32'h999;
      applyStimulus(32'h3333_0048, 2, 32'h48);
      PC_SEL = 2'b00;
      checkOutput("pc_after_fetch_noise", 64'(PC), 64'h48);

      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'h100, 32'h100);
      applyStimulus(32'h4444_0100, 0, 32'h100);
      exec(2'b10, 1'b1, 1'b0, 64'h0000_0000_03FF_FFFE, 32'h0, 32'hF8);
      applyStimulus(32'h5555_00F8, 0, 32'hF8);
      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'h100, 32'h100);
      applyStimulus(32'h6666_0100, 0, 32'h100);
      exec(2'b10, 1'b1, 1'b1, 64'h0000_0000_0000_0003, 32'h0, 32'h10C);
      applyStimulus(32'h7777_010C, 0, 32'h10C);
      exec(2'b10, 1'b1, 1'b1, 64'h0000_0000_0008_0002, 32'h0, 32'h114);
      applyStimulus(32'h8888_0114, 0, 32'h114);
      exec(2'b10, 1'b0, 1'b0, 64'h0, 32'h300, 32'h300);
      applyStimulus(32'h9999_0300, 0, 32'h300);

      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      applyStimulus(32'hAAAA_FFFC, 0, 32'hFFFF_FFFC);
      exec(2'b01, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0);
      applyStimulus(32'hBBBB_0000, 0, 32'h0);

      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'h2000, 32'h2000);
      applyStimulus(32'hCCCC_2000, 0, 32'h2000);
`ifdef INST_FETCH_ALIGN_CHK_EN
      @(posedge CLK); #1;
      PC_SEL = 2'b11; A_in = 32'h2002;
      @(posedge CLK); #1;
      PC_SEL = 2'b00;
      repeat (3) begin
         @(negedge CLK);
         checkOutput("halt_fault", 64'(alignFault), 64'd1);
         checkOutput("halt_req", 64'(mem_req), 64'd0);
         checkOutput("halt_inst", 64'(Inst), 64'(BUBBLE_W));
         checkOutput("halt_pc", 64'(PC), 64'h2000);
      end
      applyReset();
      applyStimulus(32'hCCCC_0000, 0, 32'h0);
      @(negedge CLK);
      checkOutput("fault_cleared", 64'(alignFault), 64'd0);
      pcNow = 32'h0;
`else
      exec(2'b11, 1'b0, 1'b0, 64'h0, 32'h2002, 32'h2000);
      applyStimulus(32'hCCCC_2002, 0, 32'h2000);
      pcNow = 32'h2000;
`endif

      // Reset lands in the same cycle as an ack of an open request.
      expAddrQ.push_back(pcNow + 32'd4);
      @(posedge CLK); #1;
      PC_SEL = 2'b01;
      @(posedge CLK); #1;
      PC_SEL = 2'b00;
      waitReq("mid_req");
      @(posedge CLK); #1;
      Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_0001;
      @(posedge CLK); #1;
      Reset = 1'b0; mem_ack = 1'b0;
      @(negedge CLK);
      checkOutput("mid_rst_req", 64'(mem_req), 64'd0);
      checkOutput("mid_rst_valid", 64'(inst_valid), 64'd0);
      checkOutput("mid_rst_inst", 64'(Inst), 64'(BUBBLE_W));
      checkOutput("mid_rst_pc", 64'(PC), 64'd0);
      expAddrQ.push_back(32'h0);
      applyStimulus(32'h1234_5678, 1, 32'h0);

      repeat (3) @(negedge CLK);
      checkOutput("addr_queue_drained", 64'(expAddrQ.size()), 64'd0);
      checkOutput("inst_queue_drained", 64'(expInstQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
